// File: rtl/decoder_nto2n_reg_if.sv
// Bus bundle for the registered N-to-2^N decoder: control inputs and registered selects.
interface decoder_nto2n_reg_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned W = 1 << N;

  logic [N-1:0] sel;
  logic         enable;
  logic [1:0]   mode;
  logic         dir;
  logic [W-1:0] out;
  logic [N-1:0] idx;
  logic         active;
  logic         wrap;

  modport master (
    output sel, enable, mode, dir,
    input  out, idx, active, wrap
  );

  modport slave (
    input  sel, enable, mode, dir,
    output out, idx, active, wrap
  );
endinterface

// File: rtl/decoder_nto2n_reg.sv
// Registered one-hot decoder with direct decode, wrapping scan, hold and clear modes.
module decoder_nto2n_reg #(
  parameter int unsigned N = 3
) (
  input logic                clk,
  input logic                rst_n,
  decoder_nto2n_reg_if.slave bus
);
  localparam int unsigned W = 1 << N;
  localparam logic [N-1:0] IdxMax = '1;
  localparam logic [W-1:0] OneHot0 = W'(1);

  typedef enum logic [1:0] {
    ModeDecode = 2'b00,
    ModeScan   = 2'b01,
    ModeHold   = 2'b10,
    ModeClear  = 2'b11
  } mode_e;

  logic [N-1:0] idx_d, idx_q;
  logic         active_d, active_q;
  logic         wrap_d, wrap_q;
  logic [W-1:0] out_d, out_q;

  always_comb begin
    idx_d    = idx_q;
    active_d = active_q;
    wrap_d   = 1'b0;
    if (!bus.enable) begin
      idx_d    = '0;
      active_d = 1'b0;
    end else begin
      case (mode_e'(bus.mode))
        ModeDecode: begin
          idx_d    = bus.sel;
          active_d = 1'b1;
        end
        ModeScan: begin
          if (!active_q) begin
            idx_d    = bus.sel;
            active_d = 1'b1;
          end else if (!bus.dir) begin
            idx_d  = idx_q + N'(1);
            // With a single select bit every step crosses the end of the range.
            wrap_d = (N == 1) || (idx_q == IdxMax);
          end else begin
            idx_d  = idx_q - N'(1);
            wrap_d = (N == 1) || (idx_q == '0);
          end
        end
        ModeHold: ;
        ModeClear: begin
          idx_d    = '0;
          active_d = 1'b0;
        end
        default: ;
      endcase
    end
    out_d = active_d ? (OneHot0 << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
      out_q    <= out_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.idx    = idx_q;
  assign bus.active = active_q;
  assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_decoder_nto2n_reg.sv
// Directed and randomized checks of the registered decoder at N=3 and N=1.
module tb_decoder_nto2n_reg;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  decoder_nto2n_reg_if #(.N(3)) b3 ();
  decoder_nto2n_reg_if #(.N(1)) b1 ();

  decoder_nto2n_reg #(.N(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  decoder_nto2n_reg #(.N(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [7:0] o, input logic [2:0] i,
                      input logic a, input logic w);
    chk({tag, ".out"}, 32'(b3.out), 32'(o));
    chk({tag, ".idx"}, 32'(b3.idx), 32'(i));
    chk({tag, ".active"}, 32'(b3.active), 32'(a));
    chk({tag, ".wrap"}, 32'(b3.wrap), 32'(w));
  endtask

  task automatic drive3(input logic en, input logic [1:0] m, input logic d, input logic [2:0] s);
    b3.enable = en;
    b3.mode   = m;
    b3.dir    = d;
    b3.sel    = s;
  endtask

  initial begin
    logic [7:0] exp8;
    logic [1:0] exp2;

    rst_n = 1'b0;
    drive3(1'b0, 2'b00, 1'b0, 3'd0);
    b1.enable = 1'b0;
    b1.mode   = 2'b00;
    b1.dir    = 1'b0;
    b1.sel    = 1'b0;
    repeat (2) step();
    chk3("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    chk("reset1.out", 32'(b1.out), 32'h0);
    rst_n = 1'b1;

    // Direct decode
    drive3(1'b1, 2'b00, 1'b0, 3'd5); step(); chk3("dec5", 8'h20, 3'd5, 1'b1, 1'b0);
    drive3(1'b1, 2'b00, 1'b0, 3'd0); step(); chk3("dec0", 8'h01, 3'd0, 1'b1, 1'b0);
    drive3(1'b1, 2'b00, 1'b0, 3'd3); step(); chk3("dec3", 8'h08, 3'd3, 1'b1, 1'b0);

    // Enable gating, including HOLD while disabled
    drive3(1'b0, 2'b00, 1'b0, 3'd3); step(); chk3("en_off", 8'h00, 3'd0, 1'b0, 1'b0);
    drive3(1'b1, 2'b00, 1'b0, 3'd3); step(); chk3("dec3b", 8'h08, 3'd3, 1'b1, 1'b0);
    drive3(1'b0, 2'b10, 1'b0, 3'd3); step(); chk3("en_off_hold", 8'h00, 3'd0, 1'b0, 1'b0);

    // Scan up from inactive; sel changes after the seed are ignored
    drive3(1'b1, 2'b01, 1'b0, 3'd6); step(); chk3("up_seed", 8'h40, 3'd6, 1'b1, 1'b0);
    b3.sel = 3'd2; step(); chk3("up7", 8'h80, 3'd7, 1'b1, 1'b0);
    step(); chk3("up_wrap", 8'h01, 3'd0, 1'b1, 1'b1);
    b3.sel = 3'd5; step(); chk3("up1", 8'h02, 3'd1, 1'b1, 1'b0);

    // Scan down, hold, clear
    drive3(1'b1, 2'b11, 1'b0, 3'd1); step(); chk3("clear0", 8'h00, 3'd0, 1'b0, 1'b0);
    drive3(1'b1, 2'b01, 1'b1, 3'd1); step(); chk3("dn_seed", 8'h02, 3'd1, 1'b1, 1'b0);
    step(); chk3("dn0", 8'h01, 3'd0, 1'b1, 1'b0);
    step(); chk3("dn_wrap", 8'h80, 3'd7, 1'b1, 1'b1);
    step(); chk3("dn6", 8'h40, 3'd6, 1'b1, 1'b0);
    b3.mode = 2'b10;
    for (int k = 0; k < 3; k++) begin
      step(); chk3("hold", 8'h40, 3'd6, 1'b1, 1'b0);
    end
    b3.mode = 2'b11; step(); chk3("clear1", 8'h00, 3'd0, 1'b0, 1'b0);

    // DECODE then SCAN continues from current idx without reseeding
    drive3(1'b1, 2'b00, 1'b0, 3'd3); step(); chk3("dec3c", 8'h08, 3'd3, 1'b1, 1'b0);
    drive3(1'b1, 2'b01, 1'b0, 3'd0); step(); chk3("cont", 8'h10, 3'd4, 1'b1, 1'b0);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 chk3("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    drive3(1'b1, 2'b01, 1'b0, 3'd2);
    step(); chk3("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    step(); chk3("reseed", 8'h04, 3'd2, 1'b1, 1'b0);

    // N=1 scan: toggles, wrapping on every step
    b1.enable = 1'b1; b1.mode = 2'b01; b1.dir = 1'b0; b1.sel = 1'b0;
    step();
    chk("n1_seed.out", 32'(b1.out), 32'h1);
    chk("n1_seed.wrap", 32'(b1.wrap), 32'h0);
    step();
    chk("n1_s1.out", 32'(b1.out), 32'h2);
    chk("n1_s1.idx", 32'(b1.idx), 32'h1);
    step();
    chk("n1_s2.out", 32'(b1.out), 32'h1);
    chk("n1_s2.wrap", 32'(b1.wrap), 32'h1);
    step();
    chk("n1_s3.out", 32'(b1.out), 32'h2);
    chk("n1_s3.wrap", 32'(b1.wrap), 32'h1);

    // Randomized run; structural invariants on both instances
    for (int c = 0; c < 1000; c++) begin
      b1.enable = ($urandom_range(0, 7) != 0);
      b1.mode   = 2'($urandom_range(0, 3));
      b1.dir    = 1'($urandom_range(0, 1));
      b1.sel    = 1'($urandom_range(0, 1));
      drive3(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      step();
      exp2 = b1.active ? (2'b01 << b1.idx) : 2'b00;
      exp8 = b3.active ? (8'h01 << b3.idx) : 8'h00;
      chk("n1_onehot0", 32'($onehot0(b1.out)), 32'h1);
      chk("n1_shape", 32'(b1.out), 32'(exp2));
      chk("n1_idle_idx", 32'(b1.active || (b1.idx == 1'b0)), 32'h1);
      chk("n3_onehot0", 32'($onehot0(b3.out)), 32'h1);
      chk("n3_shape", 32'(b3.out), 32'(exp8));
      chk("n3_idle_idx", 32'(b3.active || (b3.idx == 3'd0)), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
